// File: rtl/ahb_sram_ctrl_bw.sv
// AHB-Lite slave in front of a single-port synchronous SRAM: byte/halfword/word
// writes via per-lane enables, configurable read wait states, ERROR responses, RAW stall.
module ahb_sram_ctrl_bw #(
    parameter int unsigned MEM_DEPTH   = 4096,
    parameter int unsigned SRAM_AW     = 12,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic               hsel,
    input  logic               hready_in,
    input  logic               hwrite,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hsize,
    input  logic [31:0]        haddr,
    input  logic [2:0]         hburst,
    input  logic [31:0]        hwdata,
    output logic               hready,
    output logic [1:0]         hresp,
    output logic [31:0]        hrdata,
    output logic               sram_cen,
    output logic [3:0]         sram_wen,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [31:0]        sram_d,
    input  logic [31:0]        sram_q
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_RD_STALL, S_RD_WAIT, S_WR, S_ERR1, S_ERR2
    } state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_DEPTH * 4);
    localparam int unsigned WS_M1      = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;
    localparam logic [1:0]  WAIT_LOAD  = 2'(WS_M1);
    localparam state_t      RD_NEXT    = (WAIT_STATES == 0) ? S_RD : S_RD_WAIT;

    state_t             state_q, state_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [3:0]         mask_q, mask_d;
    logic [1:0]         cnt_q, cnt_d;

    logic       accept, ready_st, misalign, illegal;
    logic [3:0] mask;
    logic       unused_ok;

    assign unused_ok = ^{hburst, htrans[0]};

    always_comb begin
        accept   = hsel && hready_in && htrans[1];
        ready_st = (state_q == S_IDLE) || (state_q == S_RD) ||
                   (state_q == S_WR)   || (state_q == S_ERR2);
        misalign = 1'b1;
        mask     = 4'b0000;
        case (hsize)
            3'b000: begin misalign = 1'b0;        mask = 4'b0001 << haddr[1:0]; end
            3'b001: begin misalign = haddr[0];    mask = haddr[1] ? 4'b1100 : 4'b0011; end
            3'b010: begin misalign = |haddr[1:0]; mask = 4'b1111; end
            default: ;
        endcase
        illegal = misalign || (haddr >= ADDR_LIMIT);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        hready   = 1'b1;
        hresp    = 2'b00;
        hrdata   = '0;
        sram_cen = 1'b1;
        sram_wen = '1;
        sram_a   = '0;
        sram_d   = '0;
        // Outputs are held at reset values while hreset is high so a pending write is dropped.
        if (!hreset) begin
            case (state_q)
                S_RD:       hrdata = sram_q;
                S_RD_STALL: begin
                    hready   = 1'b0;
                    sram_cen = 1'b0;
                    sram_a   = addr_q;
                    state_d  = RD_NEXT;
                    cnt_d    = WAIT_LOAD;
                end
                S_RD_WAIT: begin
                    hready = 1'b0;
                    if (cnt_q == 2'd0) state_d = S_RD;
                    else               cnt_d   = cnt_q - 2'd1;
                end
                S_WR: begin
                    sram_cen = 1'b0;
                    sram_wen = ~mask_q;
                    sram_a   = addr_q;
                    sram_d   = hwdata;
                end
                S_ERR1: begin
                    hready  = 1'b0;
                    hresp   = 2'b01;
                    state_d = S_ERR2;
                end
                S_ERR2:  hresp = 2'b01;
                default: ;
            endcase
            if (ready_st) begin
                state_d = S_IDLE;
                if (accept) begin
                    if (illegal) begin
                        state_d = S_ERR1;
                    end else if (hwrite) begin
                        state_d = S_WR;
                        addr_d  = haddr[SRAM_AW+1:2];
                        mask_d  = mask;
                    end else if (state_q == S_WR) begin
                        // SRAM busy with the write data phase: replay the read next cycle
                        state_d = S_RD_STALL;
                        addr_d  = haddr[SRAM_AW+1:2];
                    end else begin
                        sram_cen = 1'b0;
                        sram_a   = haddr[SRAM_AW+1:2];
                        state_d  = RD_NEXT;
                        cnt_d    = WAIT_LOAD;
                    end
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ahb_sram_ctrl_bw.sv
// Directed bench for ahb_sram_ctrl_bw: zero-wait instance with cycle table plus a
// two-wait-state instance for burst timing; each drives a behavioural SRAM.
module tb_ahb_sram_ctrl_bw;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        sel0, sel2, rdy_in, hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [31:0] haddr, hwdata;

    logic        hready0, hready2, cen0, cen2;
    logic [1:0]  hresp0, hresp2;
    logic [31:0] hrdata0, hrdata2, d0, d2, q0, q2;
    logic [3:0]  wen0, wen2;
    logic [11:0] a0, a2;

    logic [31:0] mem0 [4096];
    logic [31:0] mem2 [4096];

    int passed = 0;
    int total  = 0;

    always #5 hclk = ~hclk;

    ahb_sram_ctrl_bw #(.MEM_DEPTH(4096), .SRAM_AW(12), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(sel0), .hready_in(rdy_in), .hwrite(hwrite),
        .htrans(htrans), .hsize(hsize), .haddr(haddr), .hburst(hburst), .hwdata(hwdata),
        .hready(hready0), .hresp(hresp0), .hrdata(hrdata0), .sram_cen(cen0),
        .sram_wen(wen0), .sram_a(a0), .sram_d(d0), .sram_q(q0));

    ahb_sram_ctrl_bw #(.MEM_DEPTH(4096), .SRAM_AW(12), .WAIT_STATES(2)) dut2 (
        .hclk(hclk), .hreset(hreset), .hsel(sel2), .hready_in(rdy_in), .hwrite(hwrite),
        .htrans(htrans), .hsize(hsize), .haddr(haddr), .hburst(hburst), .hwdata(hwdata),
        .hready(hready2), .hresp(hresp2), .hrdata(hrdata2), .sram_cen(cen2),
        .sram_wen(wen2), .sram_a(a2), .sram_d(d2), .sram_q(q2));

    always @(posedge hclk) begin
        if (!cen0) begin
            for (int i = 0; i < 4; i++)
                if (!wen0[i]) mem0[a0][8*i +: 8] <= d0[8*i +: 8];
            if (&wen0) q0 <= mem0[a0];
        end
    end

    always @(posedge hclk) begin
        if (!cen2) begin
            for (int i = 0; i < 4; i++)
                if (!wen2[i]) mem2[a2][8*i +: 8] <= d2[8*i +: 8];
            if (&wen2) q2 <= mem2[a2];
        end
    end

    localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NS = 2'b10, SQ = 2'b11;
    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010;

    typedef struct {
        logic        sel, rin, wr;
        logic [1:0]  trans;
        logic [2:0]  size;
        logic [31:0] addr, wdata;
        logic [83:0] exp;
    } vec_t;

    vec_t tbl [29];

    function automatic logic [83:0] pk(input logic rdy, input logic [1:0] resp,
                                       input logic [31:0] rdata, input logic cen,
                                       input logic [3:0] wen, input logic [11:0] a,
                                       input logic [31:0] d);
        return {rdy, resp, rdata, cen, wen, a, d};
    endfunction

    function automatic vec_t mk(input logic sel, input logic rin, input logic [1:0] trans,
                                input logic wr, input logic [2:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [83:0] exp);
        vec_t v;
        v.sel = sel; v.rin = rin; v.trans = trans; v.wr = wr; v.size = size;
        v.addr = addr; v.wdata = wdata; v.exp = exp;
        return v;
    endfunction

    function automatic logic [83:0] act0();
        return {hready0, hresp0, hrdata0, cen0, wen0, a0, d0};
    endfunction

    function automatic logic [83:0] act2();
        return {hready2, hresp2, hrdata2, cen2, wen2, a2, d2};
    endfunction

    task automatic check(input string nm, input int idx, input logic [83:0] act,
                         input logic [83:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    endtask

    task automatic setbus(input logic s0, input logic s2, input logic rin, input logic [1:0] tr,
                          input logic wr, input logic [2:0] sz, input logic [31:0] ad,
                          input logic [31:0] wd);
        sel0 = s0; sel2 = s2; rdy_in = rin; htrans = tr; hwrite = wr;
        hsize = sz; haddr = ad; hwdata = wd;
    endtask

    logic [83:0] IDLE_EXP;
    logic [31:0] bval [4];
    int          low;
    bit          done;

    initial begin
        IDLE_EXP = pk(1'b1, 2'b00, 32'h0, 1'b1, 4'hF, 12'h0, 32'h0);
        hburst = 3'b000;
        tbl[0]  = mk(1, 1, NS,  1, W, 32'h10,   32'h0,        IDLE_EXP);
        tbl[1]  = mk(0, 1, IDL, 0, W, 32'h0,    32'hDEADBEEF, pk(1, 0, 0, 0, 4'h0, 12'd4, 32'hDEADBEEF));
        tbl[2]  = mk(1, 1, NS,  0, W, 32'h10,   32'h0,        pk(1, 0, 0, 0, 4'hF, 12'd4, 0));
        tbl[3]  = mk(0, 1, IDL, 0, W, 32'h0,    32'h0,        pk(1, 0, 32'hDEADBEEF, 1, 4'hF, 0, 0));
        tbl[4]  = mk(1, 1, NS,  1, B, 32'h13,   32'h0,        IDLE_EXP);
        tbl[5]  = mk(1, 1, NS,  1, H, 32'h10,   32'h55000000, pk(1, 0, 0, 0, 4'b0111, 12'd4, 32'h55000000));
        tbl[6]  = mk(0, 1, IDL, 0, W, 32'h0,    32'h0000A5A5, pk(1, 0, 0, 0, 4'b1100, 12'd4, 32'h0000A5A5));
        tbl[7]  = mk(1, 1, NS,  0, W, 32'h10,   32'h0,        pk(1, 0, 0, 0, 4'hF, 12'd4, 0));
        tbl[8]  = mk(0, 1, IDL, 0, W, 32'h0,    32'h0,        pk(1, 0, 32'h55ADA5A5, 1, 4'hF, 0, 0));
        tbl[9]  = mk(1, 1, NS,  1, W, 32'h20,   32'h0,        IDLE_EXP);
        tbl[10] = mk(1, 1, NS,  0, W, 32'h20,   32'h12345678, pk(1, 0, 0, 0, 4'h0, 12'd8, 32'h12345678));
        tbl[11] = mk(0, 1, IDL, 0, W, 32'h0,    32'h0,        pk(0, 0, 0, 0, 4'hF, 12'd8, 0));
        tbl[12] = mk(0, 1, IDL, 0, W, 32'h0,    32'h0,        pk(1, 0, 32'h12345678, 1, 4'hF, 0, 0));
        tbl[13] = mk(1, 1, NS,  0, W, 32'h4000, 32'h0,        IDLE_EXP);
        tbl[14] = mk(0, 1, IDL, 0, W, 32'h0,    32'h0,        pk(0, 2'b01, 0, 1, 4'hF, 0, 0));
        tbl[15] = mk(1, 1, NS,  0, W, 32'h02,   32'h0,        pk(1, 2'b01, 0, 1, 4'hF, 0, 0));
        tbl[16] = mk(0, 1, IDL, 0, W, 32'h0,    32'h0,        pk(0, 2'b01, 0, 1, 4'hF, 0, 0));
        tbl[17] = mk(0, 1, IDL, 0, W, 32'h0,    32'h0,        pk(1, 2'b01, 0, 1, 4'hF, 0, 0));
        tbl[18] = mk(0, 1, NS,  0, W, 32'h10,   32'h0,        IDLE_EXP);
        tbl[19] = mk(1, 0, NS,  0, W, 32'h10,   32'h0,        IDLE_EXP);
        tbl[20] = mk(1, 1, BSY, 0, W, 32'h10,   32'h0,        IDLE_EXP);
        tbl[21] = mk(1, 1, NS,  0, W, 32'h20,   32'h0,        pk(1, 0, 0, 0, 4'hF, 12'd8, 0));
        tbl[22] = mk(1, 1, NS,  1, B, 32'h20,   32'h0,        pk(1, 0, 32'h12345678, 1, 4'hF, 0, 0));
        tbl[23] = mk(0, 1, IDL, 0, W, 32'h0,    32'h000000AA, pk(1, 0, 0, 0, 4'b1110, 12'd8, 32'h000000AA));
        tbl[24] = mk(1, 1, NS,  0, W, 32'h20,   32'h0,        pk(1, 0, 0, 0, 4'hF, 12'd8, 0));
        tbl[25] = mk(0, 1, IDL, 0, W, 32'h0,    32'h0,        pk(1, 0, 32'h123456AA, 1, 4'hF, 0, 0));
        tbl[26] = mk(1, 1, NS,  0, 3'b011, 32'h0, 32'h0,      IDLE_EXP);
        tbl[27] = mk(0, 1, IDL, 0, W, 32'h0,    32'h0,        pk(0, 2'b01, 0, 1, 4'hF, 0, 0));
        tbl[28] = mk(0, 1, IDL, 0, W, 32'h0,    32'h0,        pk(1, 2'b01, 0, 1, 4'hF, 0, 0));

        hreset = 1'b1;
        setbus(0, 0, 1, IDL, 0, W, 32'h0, 32'h0);
        repeat (2) @(posedge hclk);
        @(negedge hclk); #1;
        check("reset0", 0, act0(), IDLE_EXP);
        check("reset2", 0, act2(), IDLE_EXP);
        hreset = 1'b0;

        for (int i = 0; i < 29; i++) begin
            @(negedge hclk);
            setbus(tbl[i].sel, 0, tbl[i].rin, tbl[i].trans, tbl[i].wr, tbl[i].size,
                   tbl[i].addr, tbl[i].wdata);
            #1;
            check("vec", i, act0(), tbl[i].exp);
        end

        // Reset during a write data phase must leave the old word in place.
        @(negedge hclk); setbus(1, 0, 1, NS, 1, W, 32'h30, 32'h0);
        @(negedge hclk); setbus(0, 0, 1, IDL, 0, W, 32'h0, 32'hCAFEF00D);
        @(negedge hclk); setbus(1, 0, 1, NS, 1, W, 32'h30, 32'h0);
        @(negedge hclk); setbus(0, 0, 1, IDL, 0, W, 32'h0, 32'h11111111);
        hreset = 1'b1;
        #1 check("rst_wr_cen", 0, 84'(cen0), 84'd1);
        @(negedge hclk); #1;
        check("rst_mid", 0, act0(), IDLE_EXP);
        hreset = 1'b0;
        @(negedge hclk); setbus(1, 0, 1, NS, 0, W, 32'h30, 32'h0);
        #1 check("rst_rd_acc", 0, act0(), pk(1, 0, 0, 0, 4'hF, 12'd12, 0));
        @(negedge hclk); setbus(0, 0, 1, IDL, 0, W, 32'h0, 32'h0);
        #1 check("rst_rd_data", 0, act0(), pk(1, 0, 32'hCAFEF00D, 1, 4'hF, 0, 0));

        // Preload four words into the wait-state instance, pipelined writes.
        for (int i = 0; i < 4; i++) bval[i] = 32'hC0DE0000 | 32'(i * 17 + 1);
        @(negedge hclk); setbus(0, 1, 1, NS, 1, W, 32'h0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge hclk);
            if (i < 4) setbus(0, 1, 1, SQ, 1, W, 32'(i * 4), bval[i-1]);
            else       setbus(0, 1, 1, IDL, 0, W, 32'h0, bval[i-1]);
        end

        // INCR4 read burst with two wait states per beat.
        hburst = 3'b011;
        @(negedge hclk); setbus(0, 1, 1, NS, 0, W, 32'h0, 32'h0);
        #1 check("burst_acc", 0, 84'({hready2, cen2}), 84'b10);
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            if (i < 3) setbus(0, 1, 1, SQ, 0, W, 32'((i + 1) * 4), 32'h0);
            else       setbus(0, 1, 1, IDL, 0, W, 32'h0, 32'h0);
            low  = 0;
            done = 1'b0;
            for (int c = 0; c < 8 && !done; c++) begin
                #1;
                if (hready2) begin
                    done = 1'b1;
                end else begin
                    low++;
                    @(negedge hclk);
                end
            end
            if (!done) check("burst_timeout", i, 84'(low), 84'd2);
            check("burst_low", i, 84'(low), 84'd2);
            check("burst_data", i, 84'({hresp2, hrdata2}), 84'({2'b00, bval[i]}));
        end
        hburst = 3'b000;
        @(negedge hclk); #1;
        check("burst_end", 0, act2(), IDLE_EXP);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
